// File: rtl/sha_auth_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : sha_auth_ctrl
// Function : Sequencer for the PMU SHA-256 authentication wrapper. It loads
//            digest and block words, pulses init, waits, then samples the
//            compare result. Optional lockout via macro SHA_AUTH_LOCKOUT_EN.
// Revision : 1.0
// ============================================================================
module sha_auth_ctrl #(
  parameter int WAIT_CYCLES = 72,
  parameter int CNT_W       = 8,
  parameter int FAIL_W      = 4,
  parameter int MAX_FAIL    = 3
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              auth_req,
  input  logic              word_valid,
  output logic              word_ready,
  input  logic [31:0]       word_data,
  output logic              busy,
  output logic              auth_done,
  output logic              auth_pass,
  output logic [FAIL_W-1:0] fail_count,
  output logic              locked,
  output logic              sha_cs,
  output logic              sha_we,
  output logic              sha_wc,
  output logic [2:0]        sha_address,
  output logic [31:0]       sha_write_data,
  input  logic              sha_digest_valid
);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_LOAD_DIG = 3'd1,
    S_LOAD_BLK = 3'd2,
    S_INIT     = 3'd3,
    S_WAIT     = 3'd4,
    S_CHECK    = 3'd5,
    S_LOCKED   = 3'd6
  } state_t;

  localparam logic [CNT_W-1:0]  c_WAIT_LOAD = CNT_W'(WAIT_CYCLES - 1);
  localparam logic [FAIL_W-1:0] c_FAIL_SAT  = {FAIL_W{1'b1}};

  // Parameter sanity is caught at elaboration rather than as silent wrap.
  if ((MAX_FAIL >= (2 ** FAIL_W)) || (WAIT_CYCLES >= (2 ** CNT_W)) || (WAIT_CYCLES < 1))
  begin : g_cfg_check
    $error("sha_auth_ctrl: illegal parameter combination");
  end

  state_t            r_state, w_state_nxt;
  logic [2:0]        r_idx, w_idx_nxt;
  logic [CNT_W-1:0]  r_cnt, w_cnt_nxt;
  logic              r_cs, w_cs_nxt;
  logic              r_we, w_we_nxt;
  logic              r_wc, w_wc_nxt;
  logic [2:0]        r_addr, w_addr_nxt;
  logic [31:0]       r_data, w_data_nxt;
  logic              r_done, w_done_nxt;
  logic              r_pass, w_pass_nxt;
  logic [FAIL_W-1:0] r_fail, w_fail_nxt;
  logic [FAIL_W-1:0] w_fail_inc;

  assign w_fail_inc = (r_fail == c_FAIL_SAT) ? r_fail : r_fail + 1'b1;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
      r_idx   <= 3'd0;
      r_cnt   <= '0;
      r_cs    <= 1'b0;
      r_we    <= 1'b0;
      r_wc    <= 1'b0;
      r_addr  <= 3'd0;
      r_data  <= 32'd0;
      r_done  <= 1'b0;
      r_pass  <= 1'b0;
      r_fail  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_idx   <= w_idx_nxt;
      r_cnt   <= w_cnt_nxt;
      r_cs    <= w_cs_nxt;
      r_we    <= w_we_nxt;
      r_wc    <= w_wc_nxt;
      r_addr  <= w_addr_nxt;
      r_data  <= w_data_nxt;
      r_done  <= w_done_nxt;
      r_pass  <= w_pass_nxt;
      r_fail  <= w_fail_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    w_cnt_nxt   = r_cnt;
    w_cs_nxt    = 1'b0;
    w_we_nxt    = 1'b0;
    w_wc_nxt    = r_wc;
    w_addr_nxt  = r_addr;
    w_data_nxt  = r_data;
    w_done_nxt  = 1'b0;
    w_pass_nxt  = r_pass;
    w_fail_nxt  = r_fail;
    case (r_state)
      S_IDLE: begin
        if (auth_req) begin
          w_state_nxt = S_LOAD_DIG;
          w_pass_nxt  = 1'b0;
          w_idx_nxt   = 3'd0;
        end
      end
      S_LOAD_DIG, S_LOAD_BLK: begin
        if (word_valid) begin
          w_we_nxt   = 1'b1;
          w_wc_nxt   = (r_state == S_LOAD_BLK);
          w_addr_nxt = r_idx;
          w_data_nxt = word_data;
          w_idx_nxt  = r_idx + 3'd1;
          if (r_idx == 3'd7) begin
            w_state_nxt = (r_state == S_LOAD_DIG) ? S_LOAD_BLK : S_INIT;
          end
        end
      end
      S_INIT: begin
        w_cs_nxt    = 1'b1;
        w_cnt_nxt   = c_WAIT_LOAD;
        w_state_nxt = S_WAIT;
      end
      S_WAIT: begin
        // The wrapper still shows the previous compare result until the new digest lands.
        if (r_cnt == '0) begin
          w_state_nxt = S_CHECK;
        end else begin
          w_cnt_nxt = r_cnt - 1'b1;
        end
      end
      S_CHECK: begin
        w_done_nxt  = 1'b1;
        w_state_nxt = S_IDLE;
        if (sha_digest_valid) begin
          w_pass_nxt = 1'b1;
          w_fail_nxt = '0;
        end else begin
          w_pass_nxt = 1'b0;
          w_fail_nxt = w_fail_inc;
`ifdef SHA_AUTH_LOCKOUT_EN
          if (w_fail_inc == FAIL_W'(MAX_FAIL)) begin
            w_state_nxt = S_LOCKED;
          end
`endif
        end
      end
      S_LOCKED: begin
        w_state_nxt = S_LOCKED;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  assign word_ready     = (r_state == S_LOAD_DIG) || (r_state == S_LOAD_BLK);
  assign busy           = (r_state != S_IDLE) && (r_state != S_LOCKED);
  assign auth_done      = r_done;
  assign auth_pass      = r_pass;
  assign fail_count     = r_fail;
  assign sha_cs         = r_cs;
  assign sha_we         = r_we;
  assign sha_wc         = r_wc;
  assign sha_address    = r_addr;
  assign sha_write_data = r_data;
`ifdef SHA_AUTH_LOCKOUT_EN
  assign locked         = (r_state == S_LOCKED);
`else
  assign locked         = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_sha_auth_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_sha_auth_ctrl
// Function : Randomised self-checking bench for sha_auth_ctrl with a
//            transaction-level reference model and a behavioural SHA wrapper.
// Revision : 1.0
// ============================================================================
module tb_sha_auth_ctrl;

  localparam int WAIT_CYCLES = 72;
  localparam int CNT_W       = 8;
  localparam int FAIL_W      = 4;
  localparam int MAX_FAIL    = 3;
  localparam int CORE_LAT    = 66;
  localparam int FAIL_SAT    = (1 << FAIL_W) - 1;

  logic              clk = 1'b0;
  logic              reset_n = 1'b0;
  logic              auth_req = 1'b0;
  logic              word_valid = 1'b0;
  logic              word_ready;
  logic [31:0]       word_data = 32'd0;
  logic              busy, auth_done, auth_pass, locked;
  logic [FAIL_W-1:0] fail_count;
  logic              sha_cs, sha_we, sha_wc;
  logic [2:0]        sha_address;
  logic [31:0]       sha_write_data;
  logic              sha_digest_valid;

  sha_auth_ctrl #(
    .WAIT_CYCLES(WAIT_CYCLES), .CNT_W(CNT_W), .FAIL_W(FAIL_W), .MAX_FAIL(MAX_FAIL)
  ) dut (
    .clk(clk), .reset_n(reset_n), .auth_req(auth_req),
    .word_valid(word_valid), .word_ready(word_ready), .word_data(word_data),
    .busy(busy), .auth_done(auth_done), .auth_pass(auth_pass),
    .fail_count(fail_count), .locked(locked), .sha_cs(sha_cs), .sha_we(sha_we),
    .sha_wc(sha_wc), .sha_address(sha_address), .sha_write_data(sha_write_data),
    .sha_digest_valid(sha_digest_valid)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  always @(posedge clk) cyc++;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Behavioural wrapper: result lands CORE_LAT cycles after init, held otherwise.
  logic wr_dv;
  int   wr_t;
  bit   wr_res;
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_dv <= 1'b0;
      wr_t  <= 0;
    end else if (sha_cs) begin
      wr_t <= CORE_LAT;
    end else if (wr_t == 1) begin
      wr_dv <= wr_res;
      wr_t  <= 0;
    end else if (wr_t > 1) begin
      wr_t <= wr_t - 1;
    end
  end
  assign sha_digest_valid = wr_dv;

  // Transaction-level reference model
  logic [35:0] exp_wr_q[$];
  bit acc_valid = 1'b0;
  int acc_edge = 0;
  int busy_end = 0;
  int cs_edge = -1;
  int done_edge = -1;
  int n_hs = 16;
  bit clr_pending = 1'b0;
  bit res_pending = 1'b0;
  bit pend_res = 1'b0;
  bit vis_pass = 1'b0;
  int vis_fc = 0;
  bit vis_locked = 1'b0;

  task automatic model_reset();
    exp_wr_q.delete();
    acc_valid = 1'b0; busy_end = 0; cs_edge = -1; done_edge = -1; n_hs = 16;
    clr_pending = 1'b0; res_pending = 1'b0;
    vis_pass = 1'b0; vis_fc = 0; vis_locked = 1'b0;
  endtask

  always @(negedge clk) begin
    if (reset_n) begin
      if (clr_pending && cyc >= acc_edge) begin
        vis_pass = 1'b0;
        clr_pending = 1'b0;
      end
      if (res_pending && cyc >= done_edge) begin
        res_pending = 1'b0;
        if (pend_res) begin
          vis_pass = 1'b1;
          vis_fc = 0;
        end else begin
          vis_pass = 1'b0;
          vis_fc = (vis_fc >= FAIL_SAT) ? FAIL_SAT : vis_fc + 1;
`ifdef SHA_AUTH_LOCKOUT_EN
          if (vis_fc == MAX_FAIL) vis_locked = 1'b1;
`endif
        end
      end
      chk("busy", busy, acc_valid && cyc >= acc_edge && cyc < busy_end);
      chk("word_ready", word_ready, acc_valid && cyc >= acc_edge && n_hs < 16);
      chk("sha_cs", sha_cs, cyc == cs_edge);
      chk("auth_done", auth_done, cyc == done_edge);
      chk("auth_pass", auth_pass, vis_pass);
      chk("fail_count", fail_count, vis_fc);
      chk("locked", locked, vis_locked);
      if (sha_we) begin
        if (exp_wr_q.size() == 0) begin
          chk("spurious_we", sha_we, 1'b0);
        end else begin
          chk("sha_write", {sha_wc, sha_address, sha_write_data}, exp_wr_q.pop_front());
        end
      end else if (exp_wr_q.size() != 0) begin
        chk("missing_we", sha_we, 1'b1);
        exp_wr_q.delete();
      end
    end
  end

  task automatic check_all_zero(input string nm);
    chk(nm, {busy, auth_done, auth_pass, fail_count, locked, sha_cs, sha_we, sha_wc,
             sha_address, sha_write_data, word_ready}, 64'd0);
  endtask

  task automatic do_reset();
    @(posedge clk); #3;
    auth_req = 1'b0; word_valid = 1'b0;
    reset_n = 1'b0;
    #1 check_all_zero("async_reset_outputs");
    model_reset();
    @(posedge clk); #3;
    reset_n = 1'b1;
  endtask

  task automatic do_txn(input bit res, input int stall_at, input int stall_len,
                        input bit stray, input int abort_after, output int lat);
    int req_cyc, st;
    bit sdone, stalling, ready_now, vld;
    logic [31:0] words[16];
    bit got_done;
    for (int k = 0; k < 16; k++) words[k] = $urandom;
    lat = -1;
    wr_res = res;
    @(posedge clk); #1;
    req_cyc = cyc;
    auth_req = 1'b1;
    acc_valid = 1'b1; acc_edge = cyc + 1; busy_end = 1 << 30; n_hs = 0;
    clr_pending = 1'b1;
    st = 0; sdone = 1'b0;
    for (int k = 0; k < 200 && n_hs < 16; k++) begin
      stalling = (n_hs == stall_at) && (st < stall_len);
      word_valid = !stalling;
      word_data = stalling ? $urandom : words[n_hs];
      ready_now = (cyc >= acc_edge) && (n_hs < 16);
      vld = word_valid;
      @(posedge clk); #1;
      if (stalling) st++;
      if (ready_now && vld) begin
        exp_wr_q.push_back({(n_hs >= 8), 3'(n_hs % 8), words[n_hs]});
        n_hs++;
        if (n_hs == 16) begin
          cs_edge = cyc + 1;
          done_edge = cyc + WAIT_CYCLES + 2;
          busy_end = done_edge;
          pend_res = res;
          res_pending = 1'b1;
        end
      end
      auth_req = stray && (n_hs == 8) && !sdone;
      if (auth_req) sdone = 1'b1;
    end
    auth_req = 1'b0;
    word_valid = 1'b0;
    chk("stream_complete", n_hs, 16);
    if (abort_after >= 0) begin
      repeat (abort_after) @(posedge clk);
      do_reset();
    end else begin
      got_done = 1'b0;
      for (int k = 0; k < 300 && !got_done; k++) begin
        @(posedge clk); #1;
        word_valid = $urandom;
        word_data = $urandom;
        if (auth_done) begin
          got_done = 1'b1;
          lat = cyc - req_cyc;
        end
      end
      word_valid = 1'b0;
      chk("done_seen", got_done, 1'b1);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    int lat;
    repeat (3) @(posedge clk);
    #1 check_all_zero("reset_outputs");
    @(posedge clk); #3;
    reset_n = 1'b1;

    repeat (100) begin
      @(posedge clk); #1;
      word_valid = $urandom;
      word_data = $urandom;
    end
    word_valid = 1'b0;

    do_txn(1'b1, -1, 0, 1'b0, -1, lat);
    chk("latency_full_rate", lat, 91);
    chk("first_pass", auth_pass, 1'b1);
    chk("first_fail_count", fail_count, 0);

`ifdef SHA_AUTH_LOCKOUT_EN
    for (int f = 1; f <= 3; f++) begin
      do_txn(1'b0, -1, 0, 1'b0, -1, lat);
      chk("fail_count_seq", fail_count, f);
    end
    chk("locked_after_third", locked, 1'b1);
    @(posedge clk); #1;
    auth_req = 1'b1;
    word_valid = 1'b1;
    repeat (20) begin
      @(posedge clk); #1;
      auth_req = 1'b0;
      chk("locked_no_ready", word_ready, 1'b0);
    end
    word_valid = 1'b0;
    do_reset();
`else
    for (int f = 1; f <= 20; f++) begin
      do_txn(1'b0, -1, 0, 1'b0, -1, lat);
      chk("fail_count_sat", fail_count, (f > 15) ? 15 : f);
    end
    chk("never_locked", locked, 1'b0);
    do_txn(1'b1, -1, 0, 1'b0, -1, lat);
    chk("pass_clears_fails", fail_count, 0);
`endif

    do_txn(1'b1, 4, 5, 1'b1, -1, lat);
    chk("latency_stalled", lat, 96);
    chk("stall_pass", auth_pass, 1'b1);

    do_txn(1'b0, -1, 0, 1'b0, 20, lat);
    do_txn(1'b1, -1, 0, 1'b0, -1, lat);
    chk("latency_after_reset", lat, 91);
    chk("pass_after_reset", auth_pass, 1'b1);

    for (int t = 0; t < 8; t++) begin
      if (vis_locked) do_reset();
      do_txn(1'($urandom_range(0, 1)), $urandom_range(0, 15), $urandom_range(0, 4),
             1'($urandom_range(0, 1)), -1, lat);
    end

    repeat (5) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
